// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-vector definitions
// for the pipelined slot ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_RSB = 3'd2,
        ALU_SHR = 3'd3,
        ALU_SRA = 3'd4,
        ALU_SHL = 3'd5,
        ALU_XOR = 3'd6,
        ALU_AND = 3'd7
    } alu_op_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands, opcode and incoming C/V
// in, result and NZCV out.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_c,
    input  logic             i_v,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [SHW-1:0]   W_SH  = SHW'(WIDTH);

    logic             w_big;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_ab;
    logic [WIDTH-1:0] w_ba;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH:0]   w_sra;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    // Amounts beyond WIDTH behave like WIDTH except for the SHR/SHL carry.
    assign w_big = i_b > W_VAL;
    assign w_sh  = w_big ? W_SH : i_b[SHW-1:0];

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_ab  = i_a - i_b;
    assign w_ba  = i_b - i_a;

    // One guard bit catches the last bit shifted out.
    assign w_shr = {i_a, 1'b0} >> w_sh;
    assign w_sra = $unsigned($signed({i_a, 1'b0}) >>> w_sh);
    assign w_shl = {1'b0, i_a} << w_sh;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (i_op)
            ALU_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_ab;
                w_c   = i_a >= i_b;
                w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_RSB: begin
                w_res = w_ba;
                w_c   = i_b >= i_a;
                w_v   = (i_b[WIDTH-1] != i_a[WIDTH-1]) &&
                        (w_res[WIDTH-1] != i_b[WIDTH-1]);
            end
            ALU_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = !w_big && w_shr[0];
            end
            ALU_SRA: begin
                w_res = w_sra[WIDTH:1];
                w_c   = w_sra[0];
            end
            ALU_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = !w_big && w_shl[WIDTH];
            end
            ALU_XOR: begin
                w_res = i_a ^ i_b;
                w_c   = i_c;
                w_v   = i_v;
            end
            ALU_AND: begin
                w_res = i_a & i_b;
                w_c   = i_c;
                w_v   = i_v;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_flags        = '0;
        o_flags[FLG_N] = w_res[WIDTH-1];
        o_flags[FLG_Z] = w_res == '0;
        o_flags[FLG_C] = w_c;
        o_flags[FLG_V] = w_v;
    end

    assign o_result = w_res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined slot ALU with valid/ready backpressure
// and an architectural NZCV register updated on output handshake.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags_q
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_res;
    flags_t           r_flags;
    flags_t           r_flags_q;

    logic             w_s2_ready;
    logic             w_s1_take;
    logic             w_s2_take;
    logic [WIDTH-1:0] w_res;
    flags_t           w_flags;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_s1_take  = in_valid && in_ready;
    assign w_s2_take  = r_s1_valid && w_s2_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else if (w_s1_take) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_op    <= in_op;
        end else if (w_s2_ready) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Logical ops inherit C/V from the committed flags, not in-flight ones.
    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_op     (r_s1_op),
        .i_c      (r_flags_q[FLG_C]),
        .i_v      (r_flags_q[FLG_V]),
        .o_result (w_res),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_flags    <= '0;
        end else if (w_s2_take) begin
            r_s2_valid <= 1'b1;
            r_res      <= w_res;
            r_flags    <= w_flags;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags_q <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_flags_q <= r_flags;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_res;
    assign out_flags  = r_flags;
    assign flags_q    = r_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against a
// queue-based behavioural model of the ALU rules.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;

    alu_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .flags_q    (flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } bun_t;

    bun_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [3:0]  m_fq = 4'h0;
    logic [31:0] cur_res = 32'h0;
    logic [3:0]  cur_fl = 4'h0;
    logic        prev_hs = 1'b0;
    logic        prev_valid = 1'b0;
    logic        acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] ref_alu(input logic [2:0] op,
            input logic [31:0] a, input logic [31:0] b,
            input logic [1:0] cv);
        logic [31:0] r;
        logic [32:0] s;
        logic        c;
        logic        v;
        r = 32'h0;
        c = 1'b0;
        v = 1'b0;
        s = 33'h0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = a >= b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: begin
                r = b - a;
                c = b >= a;
                v = (b[31] != a[31]) && (r[31] != b[31]);
            end
            3'd3: begin
                if (b == 0) r = a;
                else if (b < 32) begin r = a >> b; c = a[b-1]; end
                else if (b == 32) c = a[31];
            end
            3'd4: begin
                if (b == 0) r = a;
                else if (b < 32) begin
                    r = $signed(a) >>> b;
                    c = a[b-1];
                end else begin
                    r = {32{a[31]}};
                    c = a[31];
                end
            end
            3'd5: begin
                if (b == 0) r = a;
                else if (b < 32) begin r = a << b; c = a[32-b]; end
                else if (b == 32) c = a[0];
            end
            3'd6: begin r = a ^ b; c = cv[1]; v = cv[0]; end
            default: begin r = a & b; c = cv[1]; v = cv[0]; end
        endcase
        return {r[31], r == 32'h0, c, v, r};
    endfunction

    // One clock: check the settled outputs, then drive the next inputs.
    task automatic step(input logic iv, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ordy);
        logic [1:0]  cv;
        logic        nw;
        bun_t        t;
        logic [35:0] e;
        @(negedge clk);
        cv = m_fq[1:0];
        if (prev_hs) m_fq = cur_fl;
        nw = out_valid && (!prev_valid || prev_hs);
        if (nw) begin
            check("unexpected_out", 64'(q.size() == 0), 64'd0);
            if (q.size() > 0) begin
                t = q.pop_front();
                e = ref_alu(t.op, t.a, t.b, cv);
                cur_res = e[31:0];
                cur_fl  = e[35:32];
            end
        end
        if (out_valid) begin
            check("result", out_result, cur_res);
            check("flags", out_flags, cur_fl);
        end
        check("flags_q", flags_q, m_fq);
        in_valid  = iv;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (acc) begin
            t.op = op;
            t.a  = a;
            t.b  = b;
            q.push_back(t);
        end
        prev_hs    = out_valid && ordy;
        prev_valid = out_valid;
    endtask

    task automatic one(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef);
        step(1'b1, op, a, b, 1'b1);
        check({tag, "_acc"}, acc, 1);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check({tag, "_early"}, out_valid, 0);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_res"}, out_result, er);
        check({tag, "_flg"}, out_flags, ef);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check({tag, "_fq"}, flags_q, ef);
    endtask

    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];

    initial begin
        int nacc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ov", out_valid, 0);
        rst = 1'b0;
        #1;
        check("rst_res", out_result, 0);
        check("rst_flg", out_flags, 0);
        check("rst_fq", flags_q, 0);
        check("rst_ir", in_ready, 1);

        one("add", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
        one("sub", ALU_SUB, 32'h5, 32'h5, 32'h0, 4'b0110);
        one("xor", ALU_XOR, 32'hF0, 32'hF0, 32'h0, 4'b0110);
        one("rsb", ALU_RSB, 32'h8000_0000, 32'h0, 32'h8000_0000, 4'b1001);
        one("shr1", ALU_SHR, 32'h8000_0001, 32'd1, 32'h4000_0000, 4'b0010);
        one("sra40", ALU_SRA, 32'h8000_0001, 32'd40, 32'hFFFF_FFFF, 4'b1010);
        one("shl32", ALU_SHL, 32'h8000_0001, 32'd32, 32'h0, 4'b0110);
        one("shr0", ALU_SHR, 32'h8000_0001, 32'd0, 32'h8000_0001, 4'b1000);

        bp_a = '{32'h7FFF_FFFF, 32'h10, 32'h1234, 32'hF000_0000};
        bp_b = '{32'h5, 32'h20, 32'h1, 32'h1};
        nacc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ALU_ADD, bp_a[nacc], bp_b[nacc], 1'b0);
            if (acc) nacc++;
        end
        check("bp_inrdy", in_ready, 0);
        check("bp_nacc", nacc, 2);
        check("bp_hold", out_result, 32'h7FFF_FFFF + 32'h5);
        for (int i = 0; i < 10 && nacc < 4; i++) begin
            step(1'b1, ALU_ADD, bp_a[nacc], bp_b[nacc], 1'b1);
            if (acc) nacc++;
        end
        check("bp_all", nacc, 4);
        repeat (4) step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check("bp_drain", q.size(), 0);
        check("bp_fq", flags_q, 4'b1000);

        step(1'b1, ALU_ADD, 32'h1, 32'h2, 1'b0);
        step(1'b1, ALU_SUB, 32'h1, 32'h2, 1'b0);
        step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        check("pre_rst_ov", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_fq", flags_q, 0);
        q.delete();
        m_fq       = 4'h0;
        prev_hs    = 1'b0;
        prev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check("post_rst_ov", out_valid, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            rb = $urandom_range(0, 1) ? 32'($urandom_range(0, 40))
                                      : $urandom();
            step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                 ra, rb, $urandom_range(0, 9) < 7);
        end
        repeat (8) step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        check("final_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
